avalon_bus_arbiter: RTL and testbench
=====================================

AVALON_BUS_ARBITER -- requirements
Module: avalon_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have instruction host ports i_address in ADDR_W, i_read in 1, i_byteenable in DATA_W/8, i_readdata out DATA_W, i_readdatavalid out 1, i_waitrequest out 1.
REQ-006 SHALL have data host ports d_address in ADDR_W, d_read in 1, d_write in 1, d_byteenable in DATA_W/8, d_writedata in DATA_W, d_readdata out DATA_W, d_readdatavalid out 1, d_waitrequest out 1.
REQ-007 SHALL have agent ports m_address out ADDR_W, m_read out 1, m_write out 1, m_byteenable out DATA_W/8, m_writedata out DATA_W, m_readdata in DATA_W, m_readdatavalid in 1, m_waitrequest in 1.

Function
REQ-008 SHALL share one Avalon-MM agent port between the instruction host (read-only) and the data host (read/write), with at most one outstanding transfer.
REQ-009 SHALL implement states IDLE, GRANT_I, GRANT_D, WAIT_RD; WAIT_RD records an owner bit (I or D).
REQ-010 IDLE: request = i_read for I, d_read|d_write for D; next state GRANT_x for the winner; stays IDLE if no request; arbitration latency 1 cycle.
REQ-011 Tie in IDLE SHALL go to the host not granted last (round-robin via last_grant register); a single requester wins regardless of last_grant.
REQ-012 GRANT_x SHALL drive m_address, m_byteenable, m_read (and m_write, m_writedata for D) combinationally from host x, and x_waitrequest = m_waitrequest.
REQ-013 Data host asserting d_read and d_write together SHALL be forwarded as a write only (m_read=0).
REQ-014 GRANT_x with request accepted (m_read|m_write and !m_waitrequest): write -> IDLE; read -> WAIT_RD with owner=x; last_grant<=x in both cases.
REQ-015 GRANT_x with host request withdrawn before acceptance SHALL return to IDLE without updating last_grant.
REQ-016 WAIT_RD: m_read=m_write=0; on m_readdatavalid=1, assert owner's readdatavalid the same cycle and go IDLE.
REQ-017 i_readdata and d_readdata SHALL both equal m_readdata combinationally; only readdatavalid is steered.
REQ-018 Non-owner readdatavalid SHALL always be 0; m_readdatavalid outside WAIT_RD SHALL be dropped.
REQ-019 Host waitrequest SHALL be 1 whenever that host is not in its GRANT state (IDLE, other host's grant, WAIT_RD), so requests are held by the host.
REQ-020 When not in GRANT_x, m_address, m_byteenable, m_writedata SHALL be 0 and m_read, m_write SHALL be 0.
REQ-021 Back-to-back: minimum 2 cycles per write (IDLE+GRANT) and 3 per zero-wait read with 1-cycle data latency; no combinational path from m_readdatavalid to m_read.

Reset
REQ-022 rst=0 SHALL force state IDLE, last_grant=I, owner=I immediately, independent of clk.
REQ-023 During and after reset until a grant: m_read=m_write=0, i/d_readdatavalid=0, i/d_waitrequest=1, m_address/m_byteenable/m_writedata=0.
REQ-024 Reset mid-transfer (GRANT or WAIT_RD) SHALL abandon the transfer; a late m_readdatavalid after release SHALL not be forwarded.

Verification
REQ-025 I read 0x100, m_waitrequest=0, data 0xDEADBEEF one cycle later -> m_read high 1 cycle at 0x100, i_readdatavalid=1 with 0xDEADBEEF, d_readdatavalid=0.
REQ-026 I read and D write 0x200 data 0x12345678 BE=0xF in same cycle after reset -> D granted first (last_grant=I), write issued, then I read issued; next tie goes to D again.
REQ-027 D write with m_waitrequest=1 for 3 cycles -> m_write held, d_waitrequest=1 for 3 cycles, i_waitrequest=1 throughout, IDLE after acceptance.
REQ-028 D read 0x300 accepted, I read pending, readdatavalid delayed 5 cycles -> I stays waitrequest=1, only d_readdatavalid pulses, then I granted.
REQ-029 rst asserted in WAIT_RD, m_readdatavalid pulses 1 cycle after release -> no host readdatavalid, state IDLE, m_read=0.
REQ-030 D asserts read and write simultaneously -> m_write=1, m_read=0, no WAIT_RD entry.

Source files
------------

// File: rtl/avalon_bus_arbiter_if.sv
// Avalon-MM arbiter bundle: the instruction host port (i_*), the data host
// port (d_*) and the shared agent port (m_*) in a single interface.
//   modport slave  : arbiter view. Host requests and agent responses are inputs.
//                    Host responses and the agent request are outputs.
//   modport master : environment view. The hosts and the agent drive the
//                    arbiter through this modport.
// Parameters: ADDR_W is the address width. DATA_W is the data width.
// The byteenable width is DATA_W/8.
interface avalon_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // instruction host (read-only)
  logic [ADDR_W-1:0] i_address;
  logic              i_read;
  logic [BE_W-1:0]   i_byteenable;
  logic [DATA_W-1:0] i_readdata;
  logic              i_readdatavalid;
  logic              i_waitrequest;

  // data host (read/write)
  logic [ADDR_W-1:0] d_address;
  logic              d_read;
  logic              d_write;
  logic [BE_W-1:0]   d_byteenable;
  logic [DATA_W-1:0] d_writedata;
  logic [DATA_W-1:0] d_readdata;
  logic              d_readdatavalid;
  logic              d_waitrequest;

  // shared agent
  logic [ADDR_W-1:0] m_address;
  logic              m_read;
  logic              m_write;
  logic [BE_W-1:0]   m_byteenable;
  logic [DATA_W-1:0] m_writedata;
  logic [DATA_W-1:0] m_readdata;
  logic              m_readdatavalid;
  logic              m_waitrequest;

  modport slave (
    input  i_address, i_read, i_byteenable,
    output i_readdata, i_readdatavalid, i_waitrequest,
    input  d_address, d_read, d_write, d_byteenable, d_writedata,
    output d_readdata, d_readdatavalid, d_waitrequest,
    output m_address, m_read, m_write, m_byteenable, m_writedata,
    input  m_readdata, m_readdatavalid, m_waitrequest
  );

  modport master (
    output i_address, i_read, i_byteenable,
    input  i_readdata, i_readdatavalid, i_waitrequest,
    output d_address, d_read, d_write, d_byteenable, d_writedata,
    input  d_readdata, d_readdatavalid, d_waitrequest,
    input  m_address, m_read, m_write, m_byteenable, m_writedata,
    output m_readdata, m_readdatavalid, m_waitrequest
  );
endinterface

// File: rtl/avalon_bus_arbiter.sv
// Two-host Avalon-MM arbiter. The instruction host (read-only) and the data
// host (read/write) share one agent port, with at most one transfer
// outstanding. When both hosts request in the same cycle, the grant
// alternates between them (round-robin).
// Ports:
//   clk : clock. All state changes happen on its rising edge.
//   rst : asynchronous, active-low reset.
//   bus : avalon_bus_arbiter_if.slave, carrying the i_*, d_* and m_* signals.
module avalon_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  avalon_bus_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    WAIT_RD = 2'd3
  } state_t;

  typedef enum logic {
    HOST_I = 1'b0,
    HOST_D = 1'b1
  } host_t;

  state_t state_q, state_d;
  host_t  last_grant_q, last_grant_d;
  host_t  owner_q, owner_d;

  logic i_req;
  logic d_req;

  logic [ADDR_W-1:0] m_address_c;
  logic [BE_W-1:0]   m_byteenable_c;
  logic [DATA_W-1:0] m_writedata_c;
  logic              m_read_c;
  logic              m_write_c;
  logic              i_waitrequest_c;
  logic              d_waitrequest_c;
  logic              i_readdatavalid_c;
  logic              d_readdatavalid_c;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= HOST_I;
      owner_q      <= HOST_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    last_grant_d      = last_grant_q;
    owner_d           = owner_q;
    m_address_c       = '0;
    m_byteenable_c    = '0;
    m_writedata_c     = '0;
    m_read_c          = 1'b0;
    m_write_c         = 1'b0;
    i_waitrequest_c   = 1'b1;
    d_waitrequest_c   = 1'b1;
    i_readdatavalid_c = 1'b0;
    d_readdatavalid_c = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie, the grant goes to the host that was not served last.
        if (i_req && d_req) begin
          state_d = (last_grant_q == HOST_I) ? GRANT_D : GRANT_I;
        end else if (d_req) begin
          state_d = GRANT_D;
        end else if (i_req) begin
          state_d = GRANT_I;
        end
      end

      GRANT_I: begin
        m_address_c     = bus.i_address;
        m_byteenable_c  = bus.i_byteenable;
        m_read_c        = bus.i_read;
        i_waitrequest_c = bus.m_waitrequest;
        if (!i_req) begin
          // The host withdrew before acceptance. Nothing completed, so the
          // fairness history stays as it was.
          state_d = IDLE;
        end else if (!bus.m_waitrequest) begin
          state_d      = WAIT_RD;
          owner_d      = HOST_I;
          last_grant_d = HOST_I;
        end
      end

      GRANT_D: begin
        m_address_c     = bus.d_address;
        m_byteenable_c  = bus.d_byteenable;
        m_writedata_c   = bus.d_writedata;
        m_write_c       = bus.d_write;
        // A read and a write asserted together are forwarded as a write only.
        m_read_c        = bus.d_read & ~bus.d_write;
        d_waitrequest_c = bus.m_waitrequest;
        if (!d_req) begin
          state_d = IDLE;
        end else if (!bus.m_waitrequest) begin
          last_grant_d = HOST_D;
          if (bus.d_write) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT_RD;
            owner_d = HOST_D;
          end
        end
      end

      WAIT_RD: begin
        // The agent is quiet here, so m_read never depends on m_readdatavalid.
        if (bus.m_readdatavalid) begin
          if (owner_q == HOST_I) begin
            i_readdatavalid_c = 1'b1;
          end else begin
            d_readdatavalid_c = 1'b1;
          end
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.m_address       = m_address_c;
  assign bus.m_byteenable    = m_byteenable_c;
  assign bus.m_writedata     = m_writedata_c;
  assign bus.m_read          = m_read_c;
  assign bus.m_write         = m_write_c;
  assign bus.i_waitrequest   = i_waitrequest_c;
  assign bus.d_waitrequest   = d_waitrequest_c;
  assign bus.i_readdatavalid = i_readdatavalid_c;
  assign bus.d_readdatavalid = d_readdatavalid_c;
  // Both hosts see the read data. Only the valid strobe is steered.
  assign bus.i_readdata      = bus.m_readdata;
  assign bus.d_readdata      = bus.m_readdata;
endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Testbench for avalon_bus_arbiter. It checks the arbiter in three ways:
// a table of per-cycle vectors, hand-written multi-cycle sequences, and a
// randomized host/agent run checked against a transaction-level scoreboard.
module tb_avalon_bus_arbiter;
  logic clk;
  logic rst;

  avalon_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] ir, dr, dw, ia, da, wd, mwr, mrdv, mrd;
    logic [31:0] emr, emw, ema, embe, eiwr, edwr, eirdv, edrdv;
  } vec_t;
  vec_t vq[$];

  typedef struct {
    logic        pend, wait_data, rd, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    int          start;
  } hreq_t;
  hreq_t hi, hd;
  int          rd_cnt;
  logic [31:0] rd_data;
  int          owner_exp;
  int          last_acc;
  int          last_acc_cyc;
  int          cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] emr, emw, ema, embe, emwd,
                         input logic [31:0] eiwr, edwr, eirdv, edrdv);
    chk({tag, " m_read"}, 32'(bus.m_read), emr);
    chk({tag, " m_write"}, 32'(bus.m_write), emw);
    chk({tag, " m_address"}, bus.m_address, ema);
    chk({tag, " m_byteenable"}, 32'(bus.m_byteenable), embe);
    chk({tag, " m_writedata"}, bus.m_writedata, emwd);
    chk({tag, " i_waitrequest"}, 32'(bus.i_waitrequest), eiwr);
    chk({tag, " d_waitrequest"}, 32'(bus.d_waitrequest), edwr);
    chk({tag, " i_readdatavalid"}, 32'(bus.i_readdatavalid), eirdv);
    chk({tag, " d_readdatavalid"}, 32'(bus.d_readdatavalid), edrdv);
  endtask

  task automatic drive(input logic [31:0] ir, dr, dw, ia, da, wd, mwr, mrdv, mrd);
    bus.i_read          = ir[0];
    bus.d_read          = dr[0];
    bus.d_write         = dw[0];
    bus.i_address       = ia;
    bus.d_address       = da;
    bus.d_writedata     = wd;
    bus.m_waitrequest   = mwr[0];
    bus.m_readdatavalid = mrdv[0];
    bus.m_readdata      = mrd;
  endtask

  task automatic v(input logic [31:0] ir, dr, dw, ia, da, wd, mwr, mrdv, mrd,
                   input logic [31:0] emr, emw, ema, embe, eiwr, edwr, eirdv, edrdv);
    vec_t r;
    r.ir = ir;  r.dr = dr;  r.dw = dw;  r.ia = ia;  r.da = da;  r.wd = wd;
    r.mwr = mwr; r.mrdv = mrdv; r.mrd = mrd;
    r.emr = emr; r.emw = emw; r.ema = ema; r.embe = embe;
    r.eiwr = eiwr; r.edwr = edwr; r.eirdv = eirdv; r.edrdv = edrdv;
    vq.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Randomized run. Each host holds its request until it sees waitrequest
  // low, then waits for its read data before it issues the next request.
  // The agent inserts random wait states and answers reads after 1..4 cycles.
  task automatic run_random(input int ncyc, input bit gen);
    logic        acc_i, acc_d, acc_m, m_act, rdv_now, viol;
    logic [31:0] rdata_drv;
    int          k;
    for (int n = 0; n < ncyc; n++) begin
      step();
      cyc++;
      if (gen && !hi.pend && !hi.wait_data && $urandom_range(0, 2) == 0) begin
        hi.pend = 1'b1; hi.rd = 1'b1; hi.wr = 1'b0;
        hi.addr = $urandom; hi.be = 4'($urandom); hi.wdata = '0; hi.start = cyc;
      end
      if (gen && !hd.pend && !hd.wait_data && $urandom_range(0, 2) == 0) begin
        k = int'($urandom_range(0, 2));
        hd.pend = 1'b1; hd.rd = (k != 1); hd.wr = (k != 0);
        hd.addr = $urandom; hd.be = 4'($urandom); hd.wdata = $urandom; hd.start = cyc;
      end
      bus.i_read       = hi.pend;
      bus.i_address    = hi.addr;
      bus.i_byteenable = hi.be;
      bus.d_read       = hd.pend & hd.rd;
      bus.d_write      = hd.pend & hd.wr;
      bus.d_address    = hd.addr;
      bus.d_byteenable = hd.be;
      bus.d_writedata  = hd.wdata;
      rdv_now = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) rdv_now = 1'b1;
      end
      rdata_drv = rdv_now ? rd_data : $urandom;
      bus.m_readdatavalid = rdv_now;
      bus.m_readdata      = rdata_drv;
      bus.m_waitrequest   = ($urandom_range(0, 3) == 0);

      @(negedge clk);
      chk("rand i_readdata", bus.i_readdata, rdata_drv);
      chk("rand d_readdata", bus.d_readdata, rdata_drv);
      chk("rand i_readdatavalid", 32'(bus.i_readdatavalid), 32'(rdv_now && owner_exp == 0));
      chk("rand d_readdatavalid", 32'(bus.d_readdatavalid), 32'(rdv_now && owner_exp == 1));
      m_act = bus.m_read | bus.m_write;
      acc_m = m_act & ~bus.m_waitrequest;
      acc_i = hi.pend & ~bus.i_waitrequest;
      acc_d = hd.pend & ~bus.d_waitrequest;
      chk("rand accept match", 32'(acc_m), 32'(acc_i | acc_d));
      chk("rand accept exclusive", 32'(acc_i & acc_d), 0);
      if (owner_exp != -1) chk("rand one outstanding", 32'(m_act), 0);
      if (!m_act) begin
        chk("rand idle m_address", bus.m_address, 0);
        chk("rand idle m_byteenable", 32'(bus.m_byteenable), 0);
        chk("rand idle m_writedata", bus.m_writedata, 0);
      end
      if (rdv_now) begin
        if (owner_exp == 0) hi.wait_data = 1'b0;
        if (owner_exp == 1) hd.wait_data = 1'b0;
        owner_exp = -1;
      end
      if (acc_i) begin
        chk("rand I m_read", 32'(bus.m_read), 1);
        chk("rand I m_write", 32'(bus.m_write), 0);
        chk("rand I m_address", bus.m_address, hi.addr);
        chk("rand I m_byteenable", 32'(bus.m_byteenable), 32'(hi.be));
        viol = (last_acc == 0) && hd.pend && (hd.start <= last_acc_cyc);
        chk("rand round-robin I", 32'(viol), 0);
        chk("rand I wait bound", 32'((cyc - hi.start) <= 64), 1);
        last_acc = 0; last_acc_cyc = cyc;
        hi.pend = 1'b0; hi.wait_data = 1'b1;
        owner_exp = 0; rd_cnt = int'($urandom_range(1, 4)); rd_data = $urandom;
      end
      if (acc_d) begin
        chk("rand D m_write", 32'(bus.m_write), 32'(hd.wr));
        chk("rand D m_read", 32'(bus.m_read), 32'(hd.rd & ~hd.wr));
        chk("rand D m_address", bus.m_address, hd.addr);
        chk("rand D m_byteenable", 32'(bus.m_byteenable), 32'(hd.be));
        if (hd.wr) chk("rand D m_writedata", bus.m_writedata, hd.wdata);
        viol = (last_acc == 1) && hi.pend && (hi.start <= last_acc_cyc);
        chk("rand round-robin D", 32'(viol), 0);
        chk("rand D wait bound", 32'((cyc - hd.start) <= 64), 1);
        last_acc = 1; last_acc_cyc = cyc;
        hd.pend = 1'b0;
        if (!hd.wr) begin
          hd.wait_data = 1'b1;
          owner_exp = 1; rd_cnt = int'($urandom_range(1, 4)); rd_data = $urandom;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.i_byteenable = 4'h3;
    bus.d_byteenable = 4'hF;

    // Each row gives one cycle's inputs and the outputs expected in that cycle.
    //  ir dr dw  ia      da      wd          mwr rdv mrd           emr emw ema     embe iwr dwr irdv drdv
    // I read 0x100 with zero wait states and 1-cycle data latency
    v(0, 0, 0, 0,      0,      0,           0, 0, 0,            0, 0, 0,      0,   1, 1, 0, 0);
    v(1, 0, 0, 'h100,  0,      0,           0, 0, 0,            0, 0, 0,      0,   1, 1, 0, 0);
    v(1, 0, 0, 'h100,  0,      0,           0, 0, 0,            1, 0, 'h100,  3,   0, 1, 0, 0);
    v(0, 0, 0, 0,      0,      0,           0, 1, 'hDEADBEEF,   0, 0, 0,      0,   1, 1, 1, 0);
    // Tie after an I grant: D goes first, then I, and the next tie goes to D
    v(1, 0, 1, 'h100,  'h200,  'h12345678,  0, 0, 0,            0, 0, 0,      0,   1, 1, 0, 0);
    v(1, 0, 1, 'h100,  'h200,  'h12345678,  0, 0, 0,            0, 1, 'h200,  'hF, 1, 0, 0, 0);
    v(1, 0, 0, 'h100,  0,      0,           0, 0, 0,            0, 0, 0,      0,   1, 1, 0, 0);
    v(1, 0, 0, 'h100,  0,      0,           0, 0, 0,            1, 0, 'h100,  3,   0, 1, 0, 0);
    v(0, 0, 0, 0,      0,      0,           0, 1, 'hCAFEF00D,   0, 0, 0,      0,   1, 1, 1, 0);
    v(1, 0, 1, 'h104,  'h204,  'hAA,        0, 0, 0,            0, 0, 0,      0,   1, 1, 0, 0);
    v(1, 0, 1, 'h104,  'h204,  'hAA,        0, 0, 0,            0, 1, 'h204,  'hF, 1, 0, 0, 0);
    v(1, 0, 0, 'h104,  0,      0,           0, 0, 0,            0, 0, 0,      0,   1, 1, 0, 0);
    v(1, 0, 0, 'h104,  0,      0,           0, 0, 0,            1, 0, 'h104,  3,   0, 1, 0, 0);
    v(0, 0, 0, 0,      0,      0,           0, 1, 'h0BADF00D,   0, 0, 0,      0,   1, 1, 1, 0);
    // D read+write together goes out as a write; a stray readdatavalid is dropped
    v(0, 1, 1, 0,      'h208,  'h55,        0, 0, 0,            0, 0, 0,      0,   1, 1, 0, 0);
    v(0, 1, 1, 0,      'h208,  'h55,        0, 0, 0,            0, 1, 'h208,  'hF, 1, 0, 0, 0);
    v(0, 0, 0, 0,      0,      0,           0, 1, 'h77777777,   0, 0, 0,      0,   1, 1, 0, 0);
    // D write held for 3 wait-state cycles
    v(0, 0, 1, 0,      'h20C,  'h77,        0, 0, 0,            0, 0, 0,      0,   1, 1, 0, 0);
    v(0, 0, 1, 0,      'h20C,  'h77,        1, 0, 0,            0, 1, 'h20C,  'hF, 1, 1, 0, 0);
    v(0, 0, 1, 0,      'h20C,  'h77,        1, 0, 0,            0, 1, 'h20C,  'hF, 1, 1, 0, 0);
    v(0, 0, 1, 0,      'h20C,  'h77,        1, 0, 0,            0, 1, 'h20C,  'hF, 1, 1, 0, 0);
    v(0, 0, 1, 0,      'h20C,  'h77,        0, 0, 0,            0, 1, 'h20C,  'hF, 1, 0, 0, 0);
    v(0, 0, 0, 0,      0,      0,           0, 0, 0,            0, 0, 0,      0,   1, 1, 0, 0);
    // I withdraws in GRANT_I: last_grant stays D, so the next tie goes to I
    v(1, 0, 0, 'h110,  0,      0,           0, 0, 0,            0, 0, 0,      0,   1, 1, 0, 0);
    v(0, 0, 0, 'h110,  0,      0,           1, 0, 0,            0, 0, 'h110,  3,   1, 1, 0, 0);
    v(1, 0, 1, 'h114,  'h210,  'h99,        0, 0, 0,            0, 0, 0,      0,   1, 1, 0, 0);
    v(1, 0, 1, 'h114,  'h210,  'h99,        0, 0, 0,            1, 0, 'h114,  3,   0, 1, 0, 0);
    v(0, 0, 1, 0,      'h210,  'h99,        0, 0, 0,            0, 0, 0,      0,   1, 1, 0, 0);
    v(0, 0, 1, 0,      'h210,  'h99,        0, 1, 'h1234,       0, 0, 0,      0,   1, 1, 1, 0);
    v(0, 0, 1, 0,      'h210,  'h99,        0, 0, 0,            0, 0, 0,      0,   1, 1, 0, 0);
    v(0, 0, 1, 0,      'h210,  'h99,        0, 0, 0,            0, 1, 'h210,  'hF, 1, 0, 0, 0);
    v(0, 0, 0, 0,      0,      0,           0, 0, 0,            0, 0, 0,      0,   1, 1, 0, 0);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_out("reset", 0, 0, 0, 0, 0, 1, 1, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    foreach (vq[k]) begin
      step();
      drive(vq[k].ir, vq[k].dr, vq[k].dw, vq[k].ia, vq[k].da, vq[k].wd,
            vq[k].mwr, vq[k].mrdv, vq[k].mrd);
      @(negedge clk);
      chk_out($sformatf("vec%0d", k), vq[k].emr, vq[k].emw, vq[k].ema, vq[k].embe,
              (vq[k].emw != 0) ? vq[k].wd : 32'h0,
              vq[k].eiwr, vq[k].edwr, vq[k].eirdv, vq[k].edrdv);
      chk($sformatf("vec%0d i_readdata", k), bus.i_readdata, vq[k].mrd);
      chk($sformatf("vec%0d d_readdata", k), bus.d_readdata, vq[k].mrd);
    end

    // D read with delayed data while an I read waits (last grant is D here)
    step(); drive(0, 1, 0, 0, 'h300, 0, 0, 0, 0);
    @(negedge clk); chk_out("dly idle", 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step(); drive(1, 1, 0, 'h120, 'h300, 0, 0, 0, 0);
    @(negedge clk); chk_out("dly grant_d", 1, 0, 'h300, 'hF, 0, 1, 0, 0, 0);
    for (int n = 0; n < 5; n++) begin
      step(); drive(1, 0, 0, 'h120, 0, 0, 0, 0, 0);
      @(negedge clk); chk_out($sformatf("dly wait%0d", n), 0, 0, 0, 0, 0, 1, 1, 0, 0);
    end
    step(); drive(1, 0, 0, 'h120, 0, 0, 0, 1, 'hABCD0300);
    @(negedge clk); chk_out("dly d_rdv", 0, 0, 0, 0, 0, 1, 1, 0, 1);
    chk("dly d_readdata", bus.d_readdata, 'hABCD0300);
    step(); drive(1, 0, 0, 'h120, 0, 0, 0, 0, 0);
    @(negedge clk); chk_out("dly idle2", 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step();
    @(negedge clk); chk_out("dly grant_i", 1, 0, 'h120, 3, 0, 0, 1, 0, 0);
    step(); drive(0, 0, 0, 0, 0, 0, 0, 1, 'h5A5A0120);
    @(negedge clk); chk_out("dly i_rdv", 0, 0, 0, 0, 0, 1, 1, 1, 0);

    // Reset in WAIT_RD (owner D), then a late readdatavalid after release
    step(); drive(0, 1, 0, 0, 'h310, 0, 0, 0, 0);
    @(negedge clk); chk_out("rst idle", 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step();
    @(negedge clk); chk_out("rst grant_d", 1, 0, 'h310, 'hF, 0, 1, 0, 0, 0);
    step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    #1 chk_out("rst during", 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step(); rst = 1'b1;
    step(); drive(0, 0, 0, 0, 0, 0, 0, 1, 'hBAD0BAD0);
    @(negedge clk); chk_out("rst late rdv", 0, 0, 0, 0, 0, 1, 1, 0, 0);
    // last_grant is back to I after reset, so this tie goes to D
    step(); drive(1, 0, 1, 'h140, 'h220, 'h1111, 0, 0, 0);
    @(negedge clk); chk_out("rst tie idle", 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step();
    @(negedge clk); chk_out("rst tie grant_d", 0, 1, 'h220, 'hF, 'h1111, 1, 0, 0, 0);

    // Asynchronous reset between clock edges drops an active write at once
    step(); drive(0, 0, 1, 0, 'h230, 'h5, 1, 0, 0);
    @(negedge clk); chk_out("async idle", 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step();
    @(negedge clk); chk_out("async grant_d", 0, 1, 'h230, 'hF, 'h5, 1, 1, 0, 0);
    #2 rst = 1'b0;
    #1 chk_out("async in reset", 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); rst = 1'b1;
    step();
    @(negedge clk); chk_out("async after", 0, 0, 0, 0, 0, 1, 1, 0, 0);

    // randomized traffic against the scoreboard, then a drain
    hi = '{default: '0};
    hd = '{default: '0};
    rd_cnt = 0; rd_data = '0; owner_exp = -1; last_acc = -1; last_acc_cyc = 0; cyc = 0;
    run_random(1500, 1'b1);
    run_random(150, 1'b0);
    chk("drain pending", 32'({hi.pend, hi.wait_data, hd.pend, hd.wait_data}), 0);
    chk("drain outstanding", 32'(rd_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
